gba_dump_scheduler: RTL and testbench

Command front end and UART-TX arbiter for the cartridge reader. Parses framed host commands from the UART receiver, validates the requested window, then sequences one dump on the pak reader. Owns the single UART transmitter, sharing it between its own response bytes and the reader's data stream. Sits between `uart_recv`/`uart_send` and `GBAPakReader`, replacing single-letter command decoding.

---
 rtl/gba_dump_scheduler.sv | 208 ++++++++++++++++++++
 tb/tb_gba_dump_scheduler.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gba_dump_scheduler.sv
// Host command front end for the cartridge reader: parses framed UART commands, validates the
// dump window, sequences one pak dump and arbitrates the single UART transmitter.
module gba_dump_scheduler #(
   parameter int unsigned TIMEOUT_CYCLES = 270000,
   parameter int unsigned MAX_LENGTH     = 16777216
) (
   input  logic        pin_clk,
   input  logic        pin_rst,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic [7:0]  tx_data,
   output logic        tx_send,
   input  logic        tx_ready,
   output logic [23:0] pak_readOffset,
   output logic [24:0] pak_readLength,
   output logic        pak_startDump,
   input  logic        pak_dumpCompleted,
   input  logic [7:0]  pak_txData,
   input  logic        pak_txSend,
   output logic        pak_txReady,
   output logic        busy
);

   localparam int unsigned CntW = ($clog2(TIMEOUT_CYCLES + 1) > 18) ?
                                  $clog2(TIMEOUT_CYCLES + 1) : 18;
   localparam logic [CntW-1:0] TimeoutVal = CntW'(TIMEOUT_CYCLES);
   localparam logic [31:0]     MaxLen     = 32'(MAX_LENGTH);
   localparam logic [7:0]      ByteAck    = 8'h06;
   localparam logic [7:0]      ByteNak    = 8'h15;
   localparam logic [7:0]      ByteEot    = 8'h04;

   typedef enum logic [2:0] {
      StIdle, StRecv, StCheck, StResp, StWaitTx, StStart, StDump, StEot
   } state_e;

   // What the byte in flight was; status values can alias ACK/EOT codes, so track it apart.
   typedef enum logic [1:0] {KindAck, KindNak, KindStat, KindEot} kind_e;

   state_e          state_q, state_d;
   kind_e           kind_q, kind_d;
   logic [7:0]      resp_q, resp_d;
   logic [55:0]     frame_q, frame_d;
   logic [2:0]      idx_q, idx_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic            flag_n_q, flag_n_d;
   logic            flag_d_q, flag_d_d;
   logic            flag_t_q, flag_t_d;
   logic            seen_low_q, seen_low_d;
   logic [23:0]     off_q, off_d;
   logic [24:0]     len_q, len_d;
   logic            busy_q, busy_d;
   logic            start_q, start_d;

   logic [23:0] frame_off;
   logic [31:0] frame_len;
   logic [25:0] frame_sum;
   logic        frame_bad;
   logic        in_dump;

   assign frame_off = frame_q[55:32];
   assign frame_len = frame_q[31:0];
   assign frame_sum = {2'b00, frame_off} + {1'b0, frame_len[24:0]};
   assign frame_bad = (frame_len == 32'd0) || (frame_len > MaxLen) || (|frame_len[31:25]) ||
                      (frame_sum > 26'h100_0000);

   always_comb begin
      state_d    = state_q;
      kind_d     = kind_q;
      resp_d     = resp_q;
      frame_d    = frame_q;
      idx_d      = idx_q;
      cnt_d      = cnt_q;
      flag_n_d   = flag_n_q;
      flag_d_d   = flag_d_q;
      flag_t_d   = flag_t_q;
      seen_low_d = seen_low_q;
      off_d      = off_q;
      len_d      = len_q;
      case (state_q)
         StIdle: begin
            idx_d = 3'd0;
            cnt_d = '0;
            if (rx_valid) begin
               case (rx_data)
                  8'h52: state_d = StRecv;
                  8'h68: begin
                     frame_d = {24'd0, 32'd96};
                     state_d = StCheck;
                  end
                  8'h3F: begin
                     resp_d  = {5'b00000, flag_t_q, flag_d_q, flag_n_q};
                     kind_d  = KindStat;
                     state_d = StResp;
                  end
                  default: ;
               endcase
            end
         end
         StRecv: begin
            if (rx_valid) begin
               frame_d = {frame_q[47:0], rx_data};
               cnt_d   = '0;
               idx_d   = idx_q + 3'd1;
               if (idx_q == 3'd6) begin
                  idx_d   = 3'd0;
                  state_d = StCheck;
               end
            end else if (cnt_q == TimeoutVal) begin
               flag_t_d = 1'b1;
               state_d  = StIdle;
            end else begin
               cnt_d = cnt_q + CntW'(1);
            end
         end
         StCheck: begin
            off_d   = frame_off;
            len_d   = frame_len[24:0];
            resp_d  = frame_bad ? ByteNak : ByteAck;
            kind_d  = frame_bad ? KindNak : KindAck;
            state_d = StResp;
         end
         StResp, StEot: begin
            seen_low_d = 1'b0;
            if (tx_ready) state_d = StWaitTx;
         end
         StWaitTx: begin
            // The byte is only gone once the transmitter has gone busy and come back idle.
            if (!tx_ready) begin
               seen_low_d = 1'b1;
            end else if (seen_low_q) begin
               seen_low_d = 1'b0;
               case (kind_q)
                  KindAck: state_d = StStart;
                  KindNak: begin
                     flag_n_d = 1'b1;
                     state_d  = StIdle;
                  end
                  KindStat: begin
                     flag_n_d = 1'b0;
                     flag_d_d = 1'b0;
                     flag_t_d = 1'b0;
                     state_d  = StIdle;
                  end
                  default: state_d = StIdle;
               endcase
            end
         end
         StStart: state_d = StDump;
         StDump: begin
            if (pak_dumpCompleted) begin
               resp_d  = ByteEot;
               kind_d  = KindEot;
               state_d = StEot;
            end
         end
         default: state_d = StIdle;
      endcase
      if (rx_valid && busy_q) flag_d_d = 1'b1;
      busy_d  = !(state_d inside {StIdle, StRecv});
      start_d = (state_d == StStart);
   end

   always_ff @(posedge pin_clk or posedge pin_rst) begin
      if (pin_rst) begin
         state_q    <= StIdle;
         kind_q     <= KindAck;
         resp_q     <= 8'h00;
         frame_q    <= '0;
         idx_q      <= 3'd0;
         cnt_q      <= '0;
         flag_n_q   <= 1'b0;
         flag_d_q   <= 1'b0;
         flag_t_q   <= 1'b0;
         seen_low_q <= 1'b0;
         off_q      <= '0;
         len_q      <= '0;
         busy_q     <= 1'b0;
         start_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         kind_q     <= kind_d;
         resp_q     <= resp_d;
         frame_q    <= frame_d;
         idx_q      <= idx_d;
         cnt_q      <= cnt_d;
         flag_n_q   <= flag_n_d;
         flag_d_q   <= flag_d_d;
         flag_t_q   <= flag_t_d;
         seen_low_q <= seen_low_d;
         off_q      <= off_d;
         len_q      <= len_d;
         busy_q     <= busy_d;
         start_q    <= start_d;
      end
   end

   // The reader owns the transmitter only while dumping; elsewhere its strobe is ignored.
   assign in_dump        = (state_q == StDump);
   assign tx_data        = in_dump ? pak_txData : resp_q;
   assign tx_send        = in_dump ? pak_txSend :
                           (((state_q == StResp) || (state_q == StEot)) && tx_ready);
   assign pak_txReady    = in_dump && tx_ready;
   assign pak_readOffset = off_q;
   assign pak_readLength = len_q;
   assign pak_startDump  = start_q;
   assign busy           = busy_q;

endmodule

// File: tb/tb_gba_dump_scheduler.sv
// Directed bench for gba_dump_scheduler with a small UART transmitter model and a pak reader
// model; every expected byte and window is worked out by hand below.
module tb_gba_dump_scheduler;

   localparam int unsigned Tout = 200;

   logic        pin_clk = 1'b0;
   logic        pin_rst = 1'b1;
   logic [7:0]  rx_data = 8'h00;
   logic        rx_valid = 1'b0;
   logic [7:0]  tx_data;
   logic        tx_send;
   logic        tx_ready = 1'b1;
   logic [23:0] pak_readOffset;
   logic [24:0] pak_readLength;
   logic        pak_startDump;
   logic        pak_dumpCompleted = 1'b0;
   logic [7:0]  pak_txData = 8'h00;
   logic        pak_txSend = 1'b0;
   logic        pak_txReady;
   logic        busy;

   int          errors = 0;
   int          checks = 0;
   logic [7:0]  tx_q[$];
   int          start_cnt = 0;
   logic [23:0] st_off = '0;
   logic [24:0] st_len = '0;
   int          viol = 0;
   int          sent_n = 0;
   int          handled_n = 0;
   int          busy_cnt = 0;

   always #5 pin_clk = ~pin_clk;

   gba_dump_scheduler #(
      .TIMEOUT_CYCLES(Tout),
      .MAX_LENGTH    (16777216)
   ) dut (
      .pin_clk          (pin_clk),
      .pin_rst          (pin_rst),
      .rx_data          (rx_data),
      .rx_valid         (rx_valid),
      .tx_data          (tx_data),
      .tx_send          (tx_send),
      .tx_ready         (tx_ready),
      .pak_readOffset   (pak_readOffset),
      .pak_readLength   (pak_readLength),
      .pak_startDump    (pak_startDump),
      .pak_dumpCompleted(pak_dumpCompleted),
      .pak_txData       (pak_txData),
      .pak_txSend       (pak_txSend),
      .pak_txReady      (pak_txReady),
      .busy             (busy)
   );

   // Monitor on the falling edge, away from the DUT's active edge.
   initial forever begin
      @(negedge pin_clk);
      if (tx_send) begin
         tx_q.push_back(tx_data);
         sent_n = sent_n + 1;
         if (!tx_ready) viol = viol + 1;
      end
      if (pak_startDump) begin
         start_cnt = start_cnt + 1;
         st_off    = pak_readOffset;
         st_len    = pak_readLength;
      end
   end

   // Transmitter: busy for five cycles after each accepted byte.
   initial forever begin
      @(posedge pin_clk);
      #1;
      if (sent_n != handled_n) begin
         handled_n = sent_n;
         tx_ready  = 1'b0;
         busy_cnt  = 5;
      end else if (busy_cnt > 0) begin
         busy_cnt = busy_cnt - 1;
         if (busy_cnt == 0) tx_ready = 1'b1;
      end
   end

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks = checks + 1;
      if (got !== exp) begin
         errors = errors + 1;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] q_at(input int i);
      if (i < tx_q.size()) return {24'd0, tx_q[i]};
      return 32'hFFFF_FFFF;
   endfunction

   task automatic step();
      @(posedge pin_clk);
      #2;
   endtask

   task automatic send_byte(input logic [7:0] b);
      step();
      rx_data  = b;
      rx_valid = 1'b1;
      step();
      rx_valid = 1'b0;
   endtask

   task automatic send_r(input logic [23:0] off, input logic [31:0] len);
      send_byte(8'h52);
      send_byte(off[23:16]);
      send_byte(off[15:8]);
      send_byte(off[7:0]);
      send_byte(len[31:24]);
      send_byte(len[23:16]);
      send_byte(len[15:8]);
      send_byte(len[7:0]);
   endtask

   task automatic wait_done(input string tag, input int n);
      bit done;
      done = 1'b0;
      for (int i = 0; i < 4000 && !done; i++) begin
         if (tx_q.size() >= n && !busy && tx_ready) done = 1'b1;
         else step();
      end
      if (!done) check_val({tag, " wait expired"}, 32'd0, 32'd1);
   endtask

   task automatic run_reader(input int exp_start, input int nbytes, input logic [7:0] seed,
                             input bit inject);
      int k;
      k = 0;
      while (start_cnt < exp_start && k < 500) begin
         step();
         k++;
      end
      check_val("start pulses", start_cnt, exp_start);
      for (int i = 0; i < nbytes; i++) begin
         k = 0;
         while (!pak_txReady && k < 100) begin
            step();
            k++;
         end
         pak_txData = seed + 8'(i);
         pak_txSend = 1'b1;
         if (inject && i == 0) begin
            rx_data  = 8'h61;
            rx_valid = 1'b1;
         end
         step();
         pak_txSend = 1'b0;
         rx_valid   = 1'b0;
         step();
      end
      pak_dumpCompleted = 1'b1;
      step();
      pak_dumpCompleted = 1'b0;
   endtask

   task automatic check_dump(input string tag, input int base, input int nbytes,
                             input logic [7:0] seed);
      check_val({tag, " ack"}, q_at(base), 32'h06);
      for (int i = 0; i < nbytes; i++) begin
         logic [7:0] e;
         e = seed + 8'(i);
         check_val({tag, " data"}, q_at(base + 1 + i), {24'd0, e});
      end
      check_val({tag, " eot"}, q_at(base + 1 + nbytes), 32'h04);
      check_val({tag, " byte count"}, tx_q.size(), base + 2 + nbytes);
      check_val({tag, " busy after eot"}, {31'd0, busy}, 32'd0);
   endtask

   task automatic do_query(input string tag, input logic [7:0] exp);
      int base;
      base = tx_q.size();
      send_byte(8'h3F);
      wait_done(tag, base + 1);
      check_val(tag, q_at(base), {24'd0, exp});
      check_val({tag, " count"}, tx_q.size(), base + 1);
   endtask

   task automatic do_nak(input string tag, input logic [23:0] off, input logic [31:0] len);
      int base;
      int s0;
      base = tx_q.size();
      s0   = start_cnt;
      send_r(off, len);
      wait_done(tag, base + 1);
      check_val(tag, q_at(base), 32'h15);
      repeat (5) step();
      check_val({tag, " no start"}, start_cnt, s0);
   endtask

   initial begin
      int base;
      int s0;
      int k;

      // Reset values
      repeat (3) step();
      check_val("rst tx_data", {24'd0, tx_data}, 32'd0);
      check_val("rst tx_send", {31'd0, tx_send}, 32'd0);
      check_val("rst offset", {8'd0, pak_readOffset}, 32'd0);
      check_val("rst length", {7'd0, pak_readLength}, 32'd0);
      check_val("rst startDump", {31'd0, pak_startDump}, 32'd0);
      check_val("rst txReady", {31'd0, pak_txReady}, 32'd0);
      check_val("rst busy", {31'd0, busy}, 32'd0);
      pin_rst = 1'b0;
      step();

      // 'h': ACK, 96-halfword dump from 0, 192 bytes passed through, then EOT
      base = tx_q.size();
      s0   = start_cnt;
      send_byte(8'h68);
      check_val("h busy in check", {31'd0, busy}, 32'd1);
      run_reader(s0 + 1, 192, 8'h30, 1'b0);
      wait_done("h", base + 194);
      check_dump("h", base, 192, 8'h30);
      check_val("h offset", {8'd0, st_off}, 32'd0);
      check_val("h length", {7'd0, st_len}, 32'd96);
      check_val("h single start", start_cnt, s0 + 1);

      // 'R' 000010 / 00000020 with cycle-exact response timing
      base = tx_q.size();
      s0   = start_cnt;
      send_r(24'h000010, 32'h0000_0020);
      check_val("R check tx_send", {31'd0, tx_send}, 32'd0);
      check_val("R check busy", {31'd0, busy}, 32'd1);
      step();
      check_val("R resp tx_send", {31'd0, tx_send}, 32'd1);
      check_val("R resp tx_data", {24'd0, tx_data}, 32'h06);
      check_val("R loaded offset", {8'd0, pak_readOffset}, 32'h10);
      check_val("R loaded length", {7'd0, pak_readLength}, 32'h20);
      run_reader(s0 + 1, 3, 8'hA0, 1'b0);
      wait_done("R", base + 5);
      check_dump("R", base, 3, 8'hA0);
      check_val("R start offset", {8'd0, st_off}, 32'h10);
      check_val("R start length", {7'd0, st_len}, 32'h20);

      // Window rejections
      do_nak("nak sum over", 24'hFFFFFF, 32'h0000_0002);
      do_nak("nak zero len", 24'h000000, 32'h0000_0000);
      do_nak("nak over max", 24'h000000, 32'h0100_0001);
      do_nak("nak high bits", 24'h000000, 32'h0200_0000);

      // Boundary: FFFFFF + 1 = 2^24 is accepted
      base = tx_q.size();
      s0   = start_cnt;
      send_r(24'hFFFFFF, 32'h0000_0001);
      run_reader(s0 + 1, 1, 8'h11, 1'b0);
      wait_done("edge", base + 3);
      check_dump("edge", base, 1, 8'h11);
      check_val("edge offset", {8'd0, st_off}, 32'hFF_FFFF);
      check_val("edge length", {7'd0, st_len}, 32'd1);

      do_query("status N", 8'h01);
      do_query("status cleared", 8'h00);

      // Partial frame abandoned by inter-byte timeout
      base = tx_q.size();
      send_byte(8'h52);
      send_byte(8'h00);
      send_byte(8'h00);
      send_byte(8'h00);
      repeat (Tout + 100) step();
      check_val("timeout no tx", tx_q.size(), base);
      check_val("timeout busy", {31'd0, busy}, 32'd0);
      do_query("status T", 8'h04);

      // Host byte during a dump is dropped and flagged
      base = tx_q.size();
      s0   = start_cnt;
      send_byte(8'h68);
      run_reader(s0 + 1, 2, 8'hC0, 1'b1);
      wait_done("drop", base + 4);
      check_dump("drop", base, 2, 8'hC0);
      do_query("status D", 8'h02);

      // Reset mid-dump clears outputs at once
      s0 = start_cnt;
      send_byte(8'h68);
      k = 0;
      while (start_cnt <= s0 && k < 500) begin
         step();
         k++;
      end
      check_val("mid start", start_cnt, s0 + 1);
      step();
      pak_txData = 8'hAA;
      pak_txSend = 1'b1;
      #1;
      check_val("dump pass send", {31'd0, tx_send}, 32'd1);
      check_val("dump pass data", {24'd0, tx_data}, 32'hAA);
      check_val("dump pass ready", {31'd0, pak_txReady}, 32'd1);
      pin_rst = 1'b1;
      #1;
      check_val("abort tx_send", {31'd0, tx_send}, 32'd0);
      check_val("abort tx_data", {24'd0, tx_data}, 32'd0);
      check_val("abort txReady", {31'd0, pak_txReady}, 32'd0);
      check_val("abort busy", {31'd0, busy}, 32'd0);
      check_val("abort length", {7'd0, pak_readLength}, 32'd0);
      pak_txSend = 1'b0;
      step();
      pin_rst = 1'b0;
      step();

      base = tx_q.size();
      s0   = start_cnt;
      send_byte(8'h68);
      run_reader(s0 + 1, 1, 8'h55, 1'b0);
      wait_done("after rst", base + 3);
      check_dump("after rst", base, 1, 8'h55);
      check_val("after rst length", {7'd0, st_len}, 32'd96);

      check_val("send while not ready", viol, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
